// File: rtl/ifetch_queue.sv
// Instruction fetch unit: pulls 128-bit I-cache lines and feeds a circular instruction queue.
// Define IFQ_PC_TRACK_EN to store a byte address per entry and drive Ifq_pc; otherwise Ifq_pc is 0.
`timescale 1ns/1ps
module ifetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  Pc_out,
    output logic         Rd_en,
    input  logic [127:0] Dout,
    input  logic         Dout_valid,
    input  logic         Jmp_branch_valid,
    input  logic [31:0]  Jmp_branch_address,
    input  logic         Ifq_rd_en,
    output logic [31:0]  Ifq_inst,
    output logic [31:0]  Ifq_pc,
    output logic         Ifq_empty
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] THRESH = CW'(QUEUE_DEPTH - 4);

    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] STALL    = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:2]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;

    logic [31:0]   instMem [QUEUE_DEPTH];

    logic          pushEn;
    logic          popEn;
    logic [1:0]    offset;
    logic [2:0]    pushNum;
    logic [3:0]    slotEn;
    logic [1:0]    slotWord [4];
    logic [PW-1:0] slotAddr [4];
    logic [31:0]   slotInst [4];
    logic          unusedBits;

    function automatic logic [31:0] lineWord(input logic [127:0] line, input logic [1:0] idx);
        case (idx)
            2'd0:    return line[127:96];
            2'd1:    return line[95:64];
            2'd2:    return line[63:32];
            default: return line[31:0];
        endcase
    endfunction

    assign unusedBits = ^Jmp_branch_address[1:0];

    assign offset    = pc_q[3:2];
    assign pushNum   = 3'd4 - {1'b0, offset};
    assign Rd_en     = (state_q == FETCH) && !reset;
    assign pushEn    = Rd_en && Dout_valid && !Jmp_branch_valid;
    assign popEn     = Ifq_rd_en && (count_q != '0) && !Jmp_branch_valid;
    assign Pc_out    = {pc_q[31:4], 4'b0000};
    assign Ifq_empty = (count_q == '0);
    assign Ifq_inst  = Ifq_empty ? 32'h0 : instMem[rdPtr_q];

    // Slot j lands at wrPtr+j and carries line word offset+j; only the first pushNum slots are live.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            slotWord[j] = offset + 2'(j);
            slotAddr[j] = wrPtr_q + PW'(j);
            slotEn[j]   = pushEn && (3'(j) < pushNum);
            slotInst[j] = lineWord(Dout, slotWord[j]);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q + (pushEn ? CW'(pushNum) : '0) - (popEn ? CW'(1) : '0);

        if (pushEn) begin
            wrPtr_d = wrPtr_q + PW'(pushNum);
            pc_d    = {pc_q[31:4] + 28'd1, 2'b00};
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end

        case (state_q)
            FETCH:    if (count_d > THRESH) state_d = STALL;
            STALL:    if (count_d <= THRESH) state_d = FETCH;
            REDIRECT: state_d = FETCH;
            default:  state_d = FETCH;
        endcase

        // A redirect overrides everything above, including a line or pop in the same cycle.
        if (Jmp_branch_valid) begin
            state_d = REDIRECT;
            pc_d    = Jmp_branch_address[31:2];
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC[31:2];
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (slotEn[j]) begin
                instMem[slotAddr[j]] <= slotInst[j];
            end
        end
    end

`ifdef IFQ_PC_TRACK_EN
    logic [31:0] pcMem [QUEUE_DEPTH];

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (slotEn[j]) begin
                pcMem[slotAddr[j]] <= {pc_q[31:4], slotWord[j], 2'b00};
            end
        end
    end

    assign Ifq_pc = Ifq_empty ? 32'h0 : pcMem[rdPtr_q];
`else
    assign Ifq_pc = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a queue-level reference model predicts fetch/stall/redirect
// behaviour and expected instruction stream; a monitor compares every DUT pop against it.
`timescale 1ns/1ps
module tb_ifetch_queue;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  Pc_out;
    logic         Rd_en;
    logic [127:0] Dout;
    logic         Dout_valid = 1'b0;
    logic         Jmp_branch_valid = 1'b0;
    logic [31:0]  Jmp_branch_address = 32'h0;
    logic         Ifq_rd_en = 1'b0;
    logic [31:0]  Ifq_inst;
    logic [31:0]  Ifq_pc;
    logic         Ifq_empty;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } sbEntry_t;

    sbEntry_t    sbQ[$];
    int          assertCount = 0;
    int          failCount = 0;

    // Reference model state: byte fetch address, queue occupancy, pending redirect bubble.
    logic [31:0] modelPc = RESET_PC;
    int          modelCount = 0;
    bit          redirectCycle = 1'b0;

    ifetch_queue #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .Pc_out             (Pc_out),
        .Rd_en              (Rd_en),
        .Dout               (Dout),
        .Dout_valid         (Dout_valid),
        .Jmp_branch_valid   (Jmp_branch_valid),
        .Jmp_branch_address (Jmp_branch_address),
        .Ifq_rd_en          (Ifq_rd_en),
        .Ifq_inst           (Ifq_inst),
        .Ifq_pc             (Ifq_pc),
        .Ifq_empty          (Ifq_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instAt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory behind the I-cache: answers the requested line combinationally.
    assign Dout = {instAt(Pc_out), instAt(Pc_out + 32'd4), instAt(Pc_out + 32'd8), instAt(Pc_out + 32'd12)};

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        bit expRdEn;
        expRdEn = !redirectCycle && (modelCount <= DEPTH - 4);
        checkValue("rd_en", {31'b0, Rd_en}, {31'b0, expRdEn});
        checkValue("pc_out", Pc_out, {modelPc[31:4], 4'b0000});
        checkValue("ifq_empty", {31'b0, Ifq_empty}, {31'b0, (modelCount == 0)});
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic modelStep();
        int       n;
        bit       fetching;
        bit       popped;
        sbEntry_t e;
        if (Jmp_branch_valid) begin
            sbQ.delete();
            modelCount    = 0;
            modelPc       = {Jmp_branch_address[31:2], 2'b00};
            redirectCycle = 1'b1;
            return;
        end
        fetching = !redirectCycle && (modelCount <= DEPTH - 4);
        n = 0;
        if (fetching && Dout_valid) begin
            n = 4 - int'(modelPc[3:2]);
            for (int k = 0; k < n; k++) begin
                e.inst = instAt(modelPc + 32'(4 * k));
`ifdef IFQ_PC_TRACK_EN
                e.pc = modelPc + 32'(4 * k);
`else
                e.pc = 32'h0;
`endif
                sbQ.push_back(e);
            end
            modelPc = {modelPc[31:4] + 28'd1, 4'b0000};
        end
        popped = Ifq_rd_en && (modelCount > 0);
        modelCount = modelCount + n - (popped ? 1 : 0);
        redirectCycle = 1'b0;
    endtask

    task automatic applyStimulus(input bit dv, input bit pop, input bit jmp, input logic [31:0] tgt);
        Dout_valid         = dv;
        Ifq_rd_en          = pop;
        Jmp_branch_valid   = jmp;
        Jmp_branch_address = tgt;
        @(negedge clk);
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
        Dout_valid       = 1'b0;
        Ifq_rd_en        = 1'b0;
        Jmp_branch_valid = 1'b0;
    endtask

    // Reset is raised between clock edges with a line on offer, so it must act asynchronously.
    task automatic applyReset();
        Dout_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkValue("rst_empty", {31'b0, Ifq_empty}, 32'd1);
        checkValue("rst_rd_en", {31'b0, Rd_en}, 32'd0);
        checkValue("rst_pc_out", Pc_out, {RESET_PC[31:4], 4'b0000});
        checkValue("rst_inst", Ifq_inst, 32'h0);
        checkValue("rst_pc", Ifq_pc, 32'h0);
        sbQ.delete();
        modelCount    = 0;
        modelPc       = {RESET_PC[31:2], 2'b00};
        redirectCycle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        Dout_valid = 1'b0;
    endtask

    // Monitor: every real pop must hand over the oldest expected instruction.
    always @(negedge clk) begin
        sbEntry_t exp;
        if (!reset && Ifq_rd_en && !Ifq_empty && !Jmp_branch_valid) begin
            if (sbQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL pop_unexpected: DUT popped 0x%08h, expected no entry", Ifq_inst);
            end else begin
                exp = sbQ.pop_front();
                checkValue("ifq_inst", Ifq_inst, exp.inst);
                checkValue("ifq_pc", Ifq_pc, exp.pc);
            end
        end
    end

    initial begin
        bit          dv;
        bit          pop;
        bit          jmp;
        logic [31:0] tgt;

        applyReset();

        // Streaming fetch with continuous pops: instruction order from consecutive lines.
        repeat (20) applyStimulus(1, 1, 0, 32'h0);

        // Fill without pops until the queue stalls, then drain back to the refetch threshold.
        applyReset();
        repeat (4) applyStimulus(1, 0, 0, 32'h0);
        checkValue("full_rd_en", {31'b0, Rd_en}, 32'd0);
        checkValue("full_pc_out", Pc_out, 32'h40);
        repeat (2) applyStimulus(1, 0, 0, 32'h0);
        checkValue("held_pc_out", Pc_out, 32'h40);
        applyStimulus(1, 1, 0, 32'h0);
        checkValue("one_pop_rd_en", {31'b0, Rd_en}, 32'd0);
        repeat (3) applyStimulus(1, 1, 0, 32'h0);
        checkValue("refill_rd_en", {31'b0, Rd_en}, 32'd1);
        repeat (12) applyStimulus(1, 1, 0, 32'h0);

        // Redirect into the middle of a line with 8 entries queued.
        applyReset();
        repeat (2) applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(1, 0, 1, 32'h108);
        checkValue("redir_empty", {31'b0, Ifq_empty}, 32'd1);
        checkValue("redir_rd_en", {31'b0, Rd_en}, 32'd0);
        checkValue("redir_pc_out", Pc_out, 32'h100);
        applyStimulus(1, 0, 0, 32'h0);
        checkValue("redir_fetch", {31'b0, Rd_en}, 32'd1);
        applyStimulus(1, 0, 0, 32'h0);
        checkValue("redir_latency", {31'b0, Ifq_empty}, 32'd0);
        checkValue("redir_head", Ifq_inst, instAt(32'h108));
        checkValue("redir_next_pc", Pc_out, 32'h110);
        repeat (2) applyStimulus(0, 1, 0, 32'h0);
        checkValue("redir_two_words", {31'b0, Ifq_empty}, 32'd1);

        // Redirect colliding with an arriving line and a pop.
        repeat (2) applyStimulus(1, 0, 0, 32'h0);
        applyStimulus(1, 1, 1, 32'h200);
        checkValue("jmp_drop_empty", {31'b0, Ifq_empty}, 32'd1);
        repeat (2) applyStimulus(1, 1, 0, 32'h0);
        checkValue("jmp_head", Ifq_inst, instAt(32'h200));

        // Cache not answering: fetch address and queue contents must hold.
        repeat (3) applyStimulus(0, 0, 0, 32'h0);
        checkValue("wait_pc_out", Pc_out, 32'h210);
        checkValue("wait_head", Ifq_inst, instAt(32'h200));
        checkValue("wait_rd_en", {31'b0, Rd_en}, 32'd1);

        // Reset in mid-stream, then fetch restarts from the reset address.
        applyReset();
        repeat (10) applyStimulus(1, 1, 0, 32'h0);

        // Randomized traffic: alternate pop-light and pop-heavy phases to reach stall often.
        for (int i = 0; i < 800; i++) begin
            dv  = ($urandom_range(0, 9) < 7);
            pop = (i < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            jmp = ($urandom_range(0, 49) == 0);
            tgt = 32'($urandom_range(0, 32'h0000_FFFF));
            applyStimulus(dv, pop, jmp, tgt);
        end

        repeat (DEPTH + 4) applyStimulus(0, 1, 0, 32'h0);
        checkValue("drain_empty", {31'b0, Ifq_empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
